// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receive front end.
//   state_t             : receive FSM states (IDLE, SHIFT)
//   SCL_IDLE/SS_N_IDLE/MOSI_IDLE : pin levels the synchronisers reset to
//   DEFAULT_DATA_WIDTH  : default received word width
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Idle levels of an undriven SPI bus in mode 0, used as synchroniser
  // reset values so that a reset never looks like a bus event.
  localparam logic SCL_IDLE  = 1'b0;
  localparam logic SS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/pin_synchronizer.sv
// ---------------------------------------------------------------------------
// pin_synchronizer
// Multi-flop synchroniser bringing one asynchronous pin into clk_i.
// Parameters:
//   STAGES    : number of flops in the chain (2 or more)
//   RESET_VAL : level the whole chain is forced to during reset
// Ports:
//   clk_i     : system clock
//   reset_n_i : asynchronous active-low reset
//   d_i       : raw asynchronous pin
//   q_o       : synchronised pin, STAGES clocks behind d_i
// ---------------------------------------------------------------------------
module pin_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_chain;

  // Shift chain: bit 0 is the metastability-exposed flop, the top bit is
  // the only one the rest of the design is allowed to look at.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/spi_rx_frontend.sv
// ---------------------------------------------------------------------------
// spi_rx_frontend
// SPI slave receive front end (mode 0, MSB first). Synchronises the raw SPI
// pins into clk_i, produces single-cycle SCL edge strobes and the frame
// enable consumed by the byte transmitter, and deserialises MOSI into words.
//
// Optional feature macro: SPI_RX_OVERRUN_DETECT_EN
//   When defined, adds data_ack_i / overrun_o and tracks unacknowledged words.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth per pin (minimum 2)
//   DATA_WIDTH  : bits per received word (minimum 2)
// Ports:
//   clk_i                   : system clock
//   reset_n_i               : asynchronous active-low reset
//   scl_i, ss_n_i, mosi_i   : raw SPI pins
//   en_o                    : frame active (registered ~ss_n_sync)
//   scl_pos_edge_detected_o : 1-cycle strobe on SCL rise inside a frame
//   scl_neg_edge_detected_o : 1-cycle strobe on SCL fall inside a frame
//   data_o                  : last complete received word (held)
//   data_valid_o            : 1-cycle strobe, data_o updated
//   first_word_o            : with data_valid_o, first word of the frame
//   frame_abort_o           : 1-cycle strobe, frame ended mid-word
//   data_ack_i  (opt)       : consumer has taken data_o
//   overrun_o   (opt)       : sticky, a word arrived before the last was acked
// ---------------------------------------------------------------------------
module spi_rx_frontend
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  scl_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic                  en_o,
  output logic                  scl_pos_edge_detected_o,
  output logic                  scl_neg_edge_detected_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  first_word_o,
  output logic                  frame_abort_o
`ifdef SPI_RX_OVERRUN_DETECT_EN
  ,
  input  logic                  data_ack_i,
  output logic                  overrun_o
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_scl_sync;
  logic w_ss_n_sync;
  logic w_mosi_sync;

  logic r_scl_prev;
  logic r_en;
  logic r_pos;
  logic r_neg;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_first;
  logic                  r_abort;
  logic                  r_word_first;

  state_t                w_state_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-2:0] w_shift_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic                  w_valid_next;
  logic                  w_first_next;
  logic                  w_abort_next;
  logic                  w_word_first_next;

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(SCL_IDLE)) u_sync_scl (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (scl_i),
    .q_o       (w_scl_sync)
  );

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(SS_N_IDLE)) u_sync_ss_n (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (ss_n_i),
    .q_o       (w_ss_n_sync)
  );

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (mosi_i),
    .q_o       (w_mosi_sync)
  );

  // Edge detection and frame enable. The strobes and en_o are registered
  // from the same synchronised ss_n sample, so a strobe can only ever be
  // high in a cycle where en_o is also high, and never while idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_scl_prev <= SCL_IDLE;
      r_en       <= 1'b0;
      r_pos      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      r_scl_prev <= w_scl_sync;
      r_en       <= ~w_ss_n_sync;
      r_pos      <= ~w_ss_n_sync & ~r_scl_prev &  w_scl_sync;
      r_neg      <= ~w_ss_n_sync &  r_scl_prev & ~w_scl_sync;
    end
  end

  // State and datapath registers for the receive FSM.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_first      <= 1'b0;
      r_abort      <= 1'b0;
      r_word_first <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_cnt_next;
      r_shift      <= w_shift_next;
      r_data       <= w_data_next;
      r_valid      <= w_valid_next;
      r_first      <= w_first_next;
      r_abort      <= w_abort_next;
      r_word_first <= w_word_first_next;
    end
  end

  // Next-state and datapath logic. A slave-select release takes priority
  // over any SCL strobe seen in the same cycle, so a bit clocked in while
  // the frame is ending is dropped. Only the low DATA_WIDTH-1 bits are kept
  // in the shift register; the final bit goes straight into data_o.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_bit_cnt;
    w_shift_next      = r_shift;
    w_data_next       = r_data;
    w_valid_next      = 1'b0;
    w_first_next      = 1'b0;
    w_abort_next      = 1'b0;
    w_word_first_next = r_word_first;

    case (r_state)
      IDLE: begin
        w_cnt_next        = '0;
        w_word_first_next = 1'b1;
        if (!w_ss_n_sync) begin
          w_state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (w_ss_n_sync) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_abort_next = (r_bit_cnt != '0);
        end else if (r_pos) begin
          w_shift_next = (DATA_WIDTH-1)'({r_shift, w_mosi_sync});
          if (r_bit_cnt == LAST_BIT) begin
            w_data_next       = {r_shift, w_mosi_sync};
            w_valid_next      = 1'b1;
            w_first_next      = r_word_first;
            w_cnt_next        = '0;
            w_word_first_next = 1'b0;
          end else begin
            w_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign en_o                    = r_en;
  assign scl_pos_edge_detected_o = r_pos;
  assign scl_neg_edge_detected_o = r_neg;
  assign data_o                  = r_data;
  assign data_valid_o            = r_valid;
  assign first_word_o            = r_first;
  assign frame_abort_o           = r_abort;

`ifdef SPI_RX_OVERRUN_DETECT_EN
  logic r_pending;
  logic r_overrun;

  // Pending tracks a presented word the consumer has not acked yet. A word
  // that is presented while an older one is still pending, and is not acked
  // in that very cycle, latches the sticky overrun flag. A simultaneous ack
  // retires the old word but the new one becomes pending. Overrun is cleared
  // in the cycle en_o rises, i.e. at the start of every new frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_valid) begin
        r_pending <= 1'b1;
      end else if (data_ack_i) begin
        r_pending <= 1'b0;
      end

      if (!r_en && !w_ss_n_sync) begin
        r_overrun <= 1'b0;
      end else if (r_valid && r_pending && !data_ack_i) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign overrun_o = r_overrun;
`endif

endmodule

// File: tb/tb_spi_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_frontend
// Self-checking bench for spi_rx_frontend. Frames are driven onto the raw
// pins; the words they should produce are queued, and a monitor checks every
// data_valid_o / frame_abort_o / strobe against those expectations.
// Optional feature macro: SPI_RX_OVERRUN_DETECT_EN (adds overrun checks).
// ---------------------------------------------------------------------------
module tb_spi_rx_frontend;

  localparam int SyncStages = 2;
  localparam int DataWidth  = 8;

  logic clock = 1'b0;
  logic resetN;
  logic scl;
  logic ssN;
  logic mosi;

  logic                 enO;
  logic                 posO;
  logic                 negO;
  logic [DataWidth-1:0] dataO;
  logic                 validO;
  logic                 firstO;
  logic                 abortO;

`ifdef SPI_RX_OVERRUN_DETECT_EN
  logic dataAck;
  logic overrunO;
  bit   ackMode  = 1'b0;
  bit   ackForce = 1'b0;
  assign dataAck = ackMode ? validO : ackForce;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [7:0] expData[$];
  bit         expFirst[$];
  int         abortExp = 0;
  int         posCount = 0;
  int         negCount = 0;
  logic [7:0] lastWord = 8'h00;

  spi_rx_frontend #(
    .SYNC_STAGES (SyncStages),
    .DATA_WIDTH  (DataWidth)
  ) dut (
    .clk_i                   (clock),
    .reset_n_i               (resetN),
    .scl_i                   (scl),
    .ss_n_i                  (ssN),
    .mosi_i                  (mosi),
    .en_o                    (enO),
    .scl_pos_edge_detected_o (posO),
    .scl_neg_edge_detected_o (negO),
    .data_o                  (dataO),
    .data_valid_o            (validO),
    .first_word_o            (firstO),
    .frame_abort_o           (abortO)
`ifdef SPI_RX_OVERRUN_DETECT_EN
    ,
    .data_ack_i              (dataAck),
    .overrun_o               (overrunO)
`endif
  );

  // Free-running 100 MHz system clock.
  always #5 clock = ~clock;

  // Hard time limit so a wedged design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n clocks; inputs always change 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sendBit(input logic b, input int half);
    mosi = b;
    tick(half);
    scl = 1'b1;
    tick(half);
    scl = 1'b0;
  endtask

  // Drive one complete frame of nBits (MSB first from payload[nBits-1]),
  // queueing the words it should yield. With measure set, the pin-to-output
  // latencies of en_o rise, the first pos strobe and en_o fall are checked.
  task automatic applyStimulus(input logic [31:0] payload, input int nBits, input int half, input bit measure);
    logic [31:0] aligned;
    int          k;
    posCount = 0;
    negCount = 0;
    aligned  = payload << (32 - nBits);
    for (int w = 0; w < nBits / 8; w++) begin
      expData.push_back(aligned[31:24]);
      expFirst.push_back(w == 0);
      lastWord = aligned[31:24];
      aligned  = aligned << 8;
    end
    if ((nBits % 8) != 0) abortExp++;

    ssN = 1'b0;
    if (measure) begin
      k = 0;
      do begin
        tick(1);
        k++;
      end while (!enO && k < 20);
      checkOutput("enRiseLatency", k, SyncStages + 1);
    end else begin
      tick(3);
    end
    tick(2);

    for (int i = nBits - 1; i >= 0; i--) begin
      if (measure && i == nBits - 1) begin
        mosi = payload[i];
        tick(half);
        scl = 1'b1;
        k = 0;
        do begin
          tick(1);
          k++;
        end while (!posO && k < 20);
        checkOutput("posStrobeLatency", k, SyncStages + 1);
        if (half > k) tick(half - k);
        scl = 1'b0;
      end else begin
        sendBit(payload[i], half);
      end
    end

    tick(half + SyncStages + 4);
    ssN = 1'b1;
    if (measure) begin
      k = 0;
      do begin
        tick(1);
        k++;
      end while (enO && k < 20);
      checkOutput("enFallLatency", k, SyncStages + 1);
    end else begin
      tick(SyncStages + 2);
    end
    tick(4);

    checkOutput("posStrobeCount", posCount, nBits);
    checkOutput("negStrobeCount", negCount, nBits);
    checkOutput("missingValid", expData.size(), 0);
    checkOutput("missingAbort", abortExp, 0);
    checkOutput("dataHeld", dataO, lastWord);
    checkOutput("enAfterFrame", enO, 0);
  endtask

  // Monitor: counts strobes, pops an expected word for every data_valid_o
  // and retires an expected abort for every frame_abort_o.
  logic [7:0] monData;
  bit         monFirst;
  always @(negedge clock) begin
    if (resetN) begin
      if (posO) posCount++;
      if (negO) negCount++;
      if ((posO || negO) && !enO) checkOutput("strobeOutsideFrame", {31'd0, posO | negO}, 0);
      if (firstO && !validO) checkOutput("firstWithoutValid", {31'd0, firstO}, 0);
      if (validO) begin
        if (expData.size() == 0) begin
          checkOutput("unexpectedValid", {31'd0, validO}, 0);
        end else begin
          monData  = expData.pop_front();
          monFirst = expFirst.pop_front();
          checkOutput("data", dataO, monData);
          checkOutput("firstWord", firstO, monFirst);
        end
      end
      if (abortO) begin
        if (abortExp == 0) checkOutput("unexpectedAbort", {31'd0, abortO}, 0);
        else abortExp--;
      end
    end
  end

  initial begin
    logic [31:0] payload;
    int          nWords;
    int          extra;
    int          half;
    logic [7:0]  partial;
    logic [7:0]  word3c;

    resetN = 1'b0;
    scl    = 1'b0;
    ssN    = 1'b1;
    mosi   = 1'b1;
    tick(3);
    checkOutput("resetEn", enO, 0);
    checkOutput("resetPos", posO, 0);
    checkOutput("resetNeg", negO, 0);
    checkOutput("resetData", dataO, 0);
    checkOutput("resetValid", validO, 0);
    checkOutput("resetFirst", firstO, 0);
    checkOutput("resetAbort", abortO, 0);
    resetN = 1'b1;
    tick(3);

    $display("[TB] single byte 0xA5");
    applyStimulus(32'hA5, 8, 4, 1'b1);

    $display("[TB] back-to-back 0x12 0x34 0xFF");
    applyStimulus(32'h1234FF, 24, 4, 1'b0);

    $display("[TB] partial frame, 3 bits of 0xC3");
    applyStimulus(32'h6, 3, 4, 1'b1);

    $display("[TB] SCL toggling with slave deselected");
    posCount = 0;
    negCount = 0;
    for (int i = 0; i < 16; i++) begin
      scl = ~scl;
      tick(3);
    end
    scl = 1'b0;
    tick(SyncStages + 3);
    checkOutput("idlePosCount", posCount, 0);
    checkOutput("idleNegCount", negCount, 0);
    checkOutput("idleEn", enO, 0);

    $display("[TB] reset in the middle of a frame");
    partial = 8'b10110000;
    ssN = 1'b0;
    tick(4);
    for (int i = 7; i >= 3; i--) sendBit(partial[i], 4);
    tick(2);
    resetN = 1'b0;
    tick(2);
    checkOutput("midResetEn", enO, 0);
    checkOutput("midResetData", dataO, 0);
    checkOutput("midResetValid", validO, 0);
    lastWord = 8'h00;
    resetN = 1'b1;
    tick(5);
    word3c = 8'h3C;
    expData.push_back(word3c);
    expFirst.push_back(1'b1);
    lastWord = word3c;
    for (int i = 7; i >= 0; i--) sendBit(word3c[i], 4);
    tick(SyncStages + 6);
    ssN = 1'b1;
    tick(SyncStages + 6);
    checkOutput("resetFrameValid", expData.size(), 0);
    checkOutput("resetFrameData", dataO, 8'h3C);
    checkOutput("resetFrameAbort", abortExp, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 10; f++) begin
      nWords  = $urandom_range(1, 3);
      extra   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      payload = $urandom;
      half    = $urandom_range(3, 6);
      applyStimulus(payload, nWords * 8 + extra, half, 1'b0);
    end

`ifdef SPI_RX_OVERRUN_DETECT_EN
    $display("[TB] overrun detection");
    ackForce = 1'b1;
    tick(1);
    ackForce = 1'b0;
    tick(1);
    applyStimulus(32'h5AC3, 16, 4, 1'b0);
    checkOutput("overrunNoAck", overrunO, 1);
    ssN = 1'b0;
    tick(SyncStages + 3);
    checkOutput("overrunClearedNewFrame", overrunO, 0);
    ssN = 1'b1;
    tick(SyncStages + 4);
    ackMode = 1'b1;
    applyStimulus(32'h9966, 16, 4, 1'b0);
    checkOutput("overrunAckCoincide", overrunO, 0);
    ackMode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
